// File: rtl/hough_frame_sched_if.sv
// Accumulator RAM bus between the frame scheduler and the Hough memory.
// master = scheduler, slave = accumulator RAM / voting datapath.
`timescale 1ns/1ps
interface hough_frame_sched_if #(
   parameter int ACC_AW = 16,
   parameter int ACC_DW = 16
) ();
   logic              acc_en;
   logic [ACC_AW-1:0] acc_addr;
   logic              acc_wr;
   logic [ACC_DW-1:0] acc_wdata;
   logic              acc_rd;
   logic [ACC_DW-1:0] acc_rdata;

   modport master (
      output acc_en, acc_addr, acc_wr, acc_wdata, acc_rd,
      input  acc_rdata
   );

   modport slave (
      input  acc_en, acc_addr, acc_wr, acc_wdata, acc_rd,
      output acc_rdata
   );
endinterface

// File: rtl/hough_frame_sched.sv
// Per-frame sequencer for the Hough accumulator: clear, accumulate, scan.
// Reports the peak bin once per frame and flags broken frame timing.
`timescale 1ns/1ps
module hough_frame_sched #(
   parameter int ACC_DEPTH     = 36000,
   parameter int ACC_AW        = 16,
   parameter int ACC_DW        = 16,
   parameter int PIX_PER_FRAME = 307200,
   parameter int PIX_CW        = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              img_vsync,
   input  logic              img_de,
   hough_frame_sched_if.master acc,
   output logic              peak_valid,
   output logic [ACC_AW-1:0] peak_addr,
   output logic [ACC_DW-1:0] peak_val,
   output logic              busy,
   output logic              overrun
);
   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_ACCUM = 3'd2;
   localparam logic [2:0] S_SCAN  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ACC_AW-1:0] LAST_ADDR = ACC_AW'(ACC_DEPTH - 1);
   localparam logic [PIX_CW-1:0] LAST_PIX  = PIX_CW'(PIX_PER_FRAME - 1);

   logic [2:0]        state_q, state_d;
   logic [ACC_AW-1:0] addr_q, addr_d;
   logic              drain_q, drain_d;
   logic [PIX_CW-1:0] pix_q, pix_d;
   logic              vs_q;
   logic              rd_pend_q;
   logic [ACC_AW-1:0] rd_addr_q;
   logic [ACC_AW-1:0] max_addr_q, max_addr_d;
   logic [ACC_DW-1:0] max_val_q, max_val_d;
   logic [ACC_AW-1:0] peak_addr_q, peak_addr_d;
   logic [ACC_DW-1:0] peak_val_q, peak_val_d;
   logic              overrun_q, overrun_d;

   logic              wr, rd, en;
   logic              vs_fall, last_addr, last_pix, upd;
   logic [ACC_AW-1:0] cur_addr;
   logic [ACC_DW-1:0] cur_val;

   assign vs_fall   = vs_q & ~img_vsync;
   assign last_addr = (addr_q == LAST_ADDR);
   assign last_pix  = img_de && (pix_q == LAST_PIX);
   // Strictly greater keeps the lowest address on ties.
   assign upd       = rd_pend_q && (acc.acc_rdata > max_val_q);
   assign cur_addr  = upd ? rd_addr_q : max_addr_q;
   assign cur_val   = upd ? acc.acc_rdata : max_val_q;

   // Next-state, phase counters and running-max tracking.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      drain_d     = drain_q;
      pix_d       = pix_q;
      max_addr_d  = cur_addr;
      max_val_d   = cur_val;
      peak_addr_d = peak_addr_q;
      peak_val_d  = peak_val_q;
      overrun_d   = overrun_q;
      wr          = 1'b0;
      rd          = 1'b0;
      en          = 1'b0;
      case (state_q)
         S_CLEAR: begin
            wr     = 1'b1;
            addr_d = addr_q + ACC_AW'(1);
            if (vs_fall) overrun_d = 1'b1;
            if (last_addr) begin
               addr_d  = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (vs_fall && enable) begin
               state_d = S_ACCUM;
               pix_d   = '0;
            end
         end
         S_ACCUM: begin
            en = img_de;
            if (img_de) pix_d = pix_q + PIX_CW'(1);
            if (last_pix) begin
               state_d    = S_SCAN;
               addr_d     = '0;
               drain_d    = 1'b0;
               max_addr_d = '0;
               max_val_d  = '0;
            end else if (vs_fall) begin
               overrun_d = 1'b1;
               state_d   = S_CLEAR;
               addr_d    = '0;
            end
         end
         S_SCAN: begin
            if (vs_fall) overrun_d = 1'b1;
            if (!drain_q) begin
               rd     = 1'b1;
               addr_d = addr_q + ACC_AW'(1);
               if (last_addr) begin
                  addr_d  = '0;
                  drain_d = 1'b1;
               end
            end else begin
               // Last read data lands this cycle; fold it into the peak.
               state_d     = S_DONE;
               drain_d     = 1'b0;
               peak_addr_d = cur_addr;
               peak_val_d  = cur_val;
            end
         end
         S_DONE: begin
            if (vs_fall) overrun_d = 1'b1;
            state_d = S_CLEAR;
            addr_d  = '0;
         end
         default: begin
            state_d = S_CLEAR;
            addr_d  = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_CLEAR;
         addr_q      <= '0;
         drain_q     <= 1'b0;
         pix_q       <= '0;
         vs_q        <= 1'b1;
         rd_pend_q   <= 1'b0;
         rd_addr_q   <= '0;
         max_addr_q  <= '0;
         max_val_q   <= '0;
         peak_addr_q <= '0;
         peak_val_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         drain_q     <= drain_d;
         pix_q       <= pix_d;
         vs_q        <= img_vsync;
         rd_pend_q   <= rd;
         rd_addr_q   <= addr_q;
         max_addr_q  <= max_addr_d;
         max_val_q   <= max_val_d;
         peak_addr_q <= peak_addr_d;
         peak_val_q  <= peak_val_d;
         overrun_q   <= overrun_d;
      end
   end

   // Strobes stay quiet while rst is held; address is zero when idle.
   assign acc.acc_en    = en & ~rst;
   assign acc.acc_wr    = wr & ~rst;
   assign acc.acc_rd    = rd & ~rst;
   assign acc.acc_addr  = ((wr | rd) && !rst) ? addr_q : '0;
   assign acc.acc_wdata = '0;

   assign peak_valid = (state_q == S_DONE) && !rst;
   assign peak_addr  = peak_addr_q;
   assign peak_val   = peak_val_q;
   assign busy       = (state_q == S_CLEAR) || (state_q == S_SCAN) ||
                       (state_q == S_DONE);
   assign overrun    = overrun_q;
endmodule

// File: tb/tb_hough_frame_sched.sv
// Directed bench for hough_frame_sched with a peak scoreboard.
// Small geometry: 8 bins, 16 pixels per frame.
`timescale 1ns/1ps
module tb_hough_frame_sched;
   localparam int DEPTH = 8;
   localparam int PIX   = 16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] v;
   } pk_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        img_vsync;
   logic        img_de;
   logic        peak_valid;
   logic [15:0] peak_addr;
   logic [15:0] peak_val;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   int peaks  = 0;
   pk_t sb[$];
   logic [15:0] rom [DEPTH] = '{16'd0, 16'd3, 16'd9, 16'd2,
                                16'd9, 16'd1, 16'd0, 16'd4};

   hough_frame_sched_if #(.ACC_AW(16), .ACC_DW(16)) bus ();

   hough_frame_sched #(
      .ACC_DEPTH(DEPTH), .ACC_AW(16), .ACC_DW(16),
      .PIX_PER_FRAME(PIX), .PIX_CW(20)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .img_vsync(img_vsync), .img_de(img_de),
      .acc(bus.master),
      .peak_valid(peak_valid), .peak_addr(peak_addr),
      .peak_val(peak_val), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Accumulator RAM model: fixed vote table, 1-cycle read latency.
   always @(posedge clk)
      if (bus.acc_rd) bus.acc_rdata <= rom[bus.acc_addr[2:0]];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus invariants and peak scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk("strobe_excl", {31'd0, bus.acc_wr & bus.acc_rd}, 0);
         if (!bus.acc_wr && !bus.acc_rd)
            chk("addr_idle", {16'd0, bus.acc_addr}, 0);
         if (peak_valid) begin
            peaks++;
            if (sb.size() == 0) begin
               chk("peak_unexpected", {31'd0, peak_valid}, 0);
            end else begin
               pk_t e;
               e = sb.pop_front();
               chk("peak_addr", {16'd0, peak_addr}, {16'd0, e.a});
               chk("peak_val", {16'd0, peak_val}, {16'd0, e.v});
            end
         end
      end
   end

   task automatic cyc(input logic vs, input logic de);
      @(negedge clk);
      img_vsync = vs;
      img_de    = de;
      #1;
   endtask

   task automatic vs_pulse();
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
   endtask

   task automatic frame(input int n, input logic exp_en);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b1);
         chk("acc_en_pix", {31'd0, bus.acc_en}, {31'd0, exp_en});
      end
   endtask

   task automatic wait_peak(input int lat);
      int k;
      k = 0;
      do begin
         cyc(1'b1, 1'b0);
         k++;
      end while (!peak_valid && k < 40);
      chk("peak_latency", k, lat);
   endtask

   initial begin
      int p0;
      rst = 1'b1; enable = 1'b1; img_vsync = 1'b1; img_de = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_peak_valid", {31'd0, peak_valid}, 0);
      chk("rst_peak_addr", {16'd0, peak_addr}, 0);
      chk("rst_peak_val", {16'd0, peak_val}, 0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i > 0) cyc(1'b1, 1'b0);
         chk("clr_wr", {31'd0, bus.acc_wr}, 1);
         chk("clr_addr", {16'd0, bus.acc_addr}, i);
      end
      cyc(1'b1, 1'b0);
      chk("wait_wr", {31'd0, bus.acc_wr}, 0);
      chk("wait_busy", {31'd0, busy}, 0);

      // Full frame with a gap in de; last pixel coincides with vsync fall.
      sb.push_back('{16'd2, 16'd9});
      vs_pulse();
      for (int i = 0; i < PIX; i++) begin
         if (i == 8) begin
            cyc(1'b1, 1'b0);
            chk("acc_en_gap", {31'd0, bus.acc_en}, 0);
         end
         cyc((i == PIX - 1) ? 1'b0 : 1'b1, 1'b1);
         chk("acc_en_pix", {31'd0, bus.acc_en}, 1);
      end
      wait_peak(DEPTH + 2);
      chk("coincide_overrun", {31'd0, overrun}, 0);
      repeat (DEPTH + 1) cyc(1'b1, 1'b0);
      chk("idle_busy", {31'd0, busy}, 0);

      // enable low: vsync fall ignored.
      enable = 1'b0;
      vs_pulse();
      frame(3, 1'b0);
      chk("dis_busy", {31'd0, busy}, 0);
      enable = 1'b1;
      cyc(1'b1, 1'b0);

      // Accepted frame with a vsync fall during SCAN.
      sb.push_back('{16'd2, 16'd9});
      vs_pulse();
      frame(PIX, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      wait_peak(DEPTH + 2 - 3);
      chk("scan_overrun", {31'd0, overrun}, 1);
      repeat (DEPTH + 1) cyc(1'b1, 1'b0);
      frame(3, 1'b0);
      vs_pulse();
      frame(PIX, 1'b1);

      // Reset in the middle of SCAN.
      for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0);
      chk("scan_rd", {31'd0, bus.acc_rd}, 1);
      chk("scan_addr5", {16'd0, bus.acc_addr}, 5);
      p0 = peaks;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_clr_wr", {31'd0, bus.acc_wr}, 1);
      chk("rst_clr_addr", {16'd0, bus.acc_addr}, 0);
      chk("rst_ovr_clear", {31'd0, overrun}, 0);
      repeat (DEPTH + 4) cyc(1'b1, 1'b0);
      chk("rst_no_peak", peaks, p0);

      // Short frame: vsync fall after 10 pixels.
      vs_pulse();
      frame(10, 1'b1);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 1'b0);
         chk("short_wr", {31'd0, bus.acc_wr}, 1);
         chk("short_addr", {16'd0, bus.acc_addr}, i);
      end
      chk("short_overrun", {31'd0, overrun}, 1);
      repeat (15) cyc(1'b1, 1'b0);
      chk("short_no_peak", peaks, p0);
      chk("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hough_frame_sched.md
Name: hough_frame_sched

Overview:
- Per-frame sequencer for the Hough accumulator RAM in the lane-detection pipeline.
- Sits between the video timing source (vsync / data enable) and the accumulator memory.
- Each frame runs three phases in order: clear the accumulator, gate accumulation during active pixels, then scan the accumulator for its peak bin.
- Reports the peak (address, vote count) once per frame and flags frames whose timing breaks the schedule.

Parameters:
- ACC_DEPTH, 36000, number of accumulator bins (theta x rho).
- ACC_AW, 16, accumulator address width; must satisfy 2^ACC_AW >= ACC_DEPTH.
- ACC_DW, 16, accumulator data width.
- PIX_PER_FRAME, 307200, active pixels per frame (640 x 480).
- PIX_CW, 20, pixel counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  when low, the block parks in WAIT_VS after the current phase chain completes.
- img_vsync  in  1  frame sync, active-low pulse.
- img_de  in  1  active pixel enable.
- acc_en  out  1  accumulate strobe to the Hough voting datapath.
- acc_addr  out  ACC_AW  accumulator address, used by clear and scan.
- acc_wr  out  1  accumulator write strobe; data is zero.
- acc_wdata  out  ACC_DW  accumulator write data; constant 0.
- acc_rd  out  1  accumulator read strobe.
- acc_rdata  in  ACC_DW  read data, valid exactly 1 cycle after acc_rd.
- peak_valid  out  1  one-cycle pulse when a peak result is ready.
- peak_addr  out  ACC_AW  bin address of the frame maximum.
- peak_val  out  ACC_DW  vote count of the frame maximum.
- busy  out  1  high in CLEAR, SCAN, DONE.
- overrun  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values:
  - state = CLEAR.
  - acc_en, acc_wr, acc_rd, peak_valid, overrun = 0.
  - acc_addr, peak_addr, peak_val = 0.
  - Pixel counter = 0; vsync history register = 1.
- vs_fall = vs_d & ~img_vsync, where vs_d is img_vsync registered.
- State machine:
  - CLEAR
    - acc_wr = 1 and acc_addr steps 0..ACC_DEPTH-1, one address per cycle (ACC_DEPTH cycles).
    - After address ACC_DEPTH-1: go to WAIT_VS.
  - WAIT_VS
    - On vs_fall with enable = 1: go to ACCUM and zero the pixel counter.
    - vs_fall with enable = 0 is ignored.
  - ACCUM
    - acc_en = img_de (combinational gate; zero added latency).
    - The pixel counter increments on each img_de.
    - When img_de is high and count == PIX_PER_FRAME-1: go to SCAN on the next cycle.
  - SCAN
    - acc_rd = 1 and acc_addr steps 0..ACC_DEPTH-1.
    - Each returning acc_rdata is compared against the running max, which is cleared to 0/addr 0 on SCAN entry.
    - The max is updated only on strictly-greater, so ties keep the lowest address.
    - After the final rdata (1 cycle after the last read): go to DONE.
  - DONE
    - peak_addr and peak_val are loaded from the running max and peak_valid = 1 for exactly one cycle.
    - Next state is CLEAR.
- peak_addr and peak_val hold their value until the next DONE.
- All-zero accumulator gives peak_addr = 0, peak_val = 0.
- acc_wr and acc_rd are never high in the same cycle.
- acc_addr is 0 whenever neither strobe is asserted.
- Timing violations:
  - vs_fall in CLEAR, SCAN or DONE: overrun <= 1; the sequence continues unchanged. The edge is not remembered, so the next frame is skipped.
  - vs_fall in ACCUM (short frame): overrun <= 1, no peak is reported, go straight to CLEAR.
  - If vs_fall and the last-pixel condition coincide in ACCUM, the last pixel wins: go to SCAN, overrun unchanged.
- enable is sampled only in WAIT_VS. Deasserting it mid-frame lets the current frame finish through DONE and CLEAR.
- rst asserted in any state returns to CLEAR on the next edge and aborts any partial clear or scan. peak_valid does not fire.
- Frame latency, last active pixel to peak_valid: ACC_DEPTH + 2 cycles.

Test Plan:
- Reset release, ACC_DEPTH = 8 → acc_wr high for 8 cycles with addr 0..7, then WAIT_VS with busy = 0.
- Full frame, PIX_PER_FRAME = 16, acc_rdata model {0,3,9,2,9,1,0,4} → acc_en mirrors img_de for 16 pixels; peak_valid pulses 10 cycles after the 16th pixel with peak_addr = 2, peak_val = 9 (tie at addr 4 ignored).
- Short frame: vs_fall after 10 of 16 pixels → overrun = 1, no peak_valid, CLEAR runs addr 0..7.
- vs_fall during SCAN → overrun = 1, peak still reported, that frame's ACCUM skipped; the following vs_fall is accepted.
- enable = 0 at vs_fall → stays in WAIT_VS, acc_en = 0 despite img_de; raise enable → next vs_fall enters ACCUM.
- rst pulse mid-SCAN at addr 5 → next cycle state CLEAR at addr 0, no peak_valid, overrun = 0.
